alu_serial_exec: RTL and testbench

Bit-serial executor for the 24-bit CPU's ALU operation set: accepts two operands and an ALU control word, then computes the result one bit per cycle, LSB first, through a single 1-bit datapath with a carry flip-flop. It is the sequencing side of the per-bit ALU slice. It drives the slice's AInvert, BInvert, CIN, Less and Op inputs over time instead of replicating the slice WIDTH times. It serves as the low-area multi-cycle ALU option and as a reference model for the parallel ALU, with the same operation encoding.

---
 rtl/alu_serial_exec.sv | 139 +++++++++++++
 tb/tb_alu_serial_exec.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_exec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_serial_exec
// Brief    : Bit-serial ALU executor, one result bit per cycle, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial_exec #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       alu_ctrl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int                 c_CNT_W  = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(WIDTH - 1);
   localparam logic [2:0]         c_OP_AND = 3'b000;
   localparam logic [2:0]         c_OP_OR  = 3'b001;
   localparam logic [2:0]         c_OP_ADD = 3'b010;
   localparam logic [2:0]         c_OP_SLT = 3'b011;
   localparam logic [2:0]         c_OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [4:0]         r_ctrl;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_carry;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry_out;
   logic               r_overflow;

   logic       w_accept;
   logic       w_last;
   logic [2:0] w_op;
   logic       w_ai;
   logic       w_bi;
   logic       w_sum;
   logic       w_cout;
   logic       w_set;
   logic       w_bit;
   logic       w_add_class;

   assign w_accept    = (r_state == S_IDLE) && start;
   assign w_last      = (r_cnt == c_LAST);
   assign w_op        = r_ctrl[2:0];
   assign w_ai        = r_a[r_cnt] ^ r_ctrl[4];
   assign w_bi        = r_b[r_cnt] ^ r_ctrl[3];
   assign w_sum       = w_ai ^ w_bi ^ r_carry;
   assign w_cout      = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);
   // Carry-in ^ carry-out at the MSB is the signed overflow; it corrects the SLT sign.
   assign w_set       = w_sum ^ (r_carry ^ w_cout);
   assign w_add_class = (w_op == c_OP_ADD) || (w_op == c_OP_SLT);

   always_comb begin
      w_bit = 1'b0;
      case (w_op)
         c_OP_AND: w_bit = w_ai & w_bi;
         c_OP_OR:  w_bit = w_ai | w_bi;
         c_OP_ADD: w_bit = w_sum;
         c_OP_XOR: w_bit = w_ai ^ w_bi;
         default:  w_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_ctrl      <= '0;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_ctrl  <= alu_ctrl;
         r_cnt   <= '0;
         r_carry <= alu_ctrl[3];
      end else if (r_state == S_RUN) begin
         r_result[r_cnt] <= w_bit;
         r_carry         <= w_cout;
         if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            // SLT bit 0 was written as 0 earlier and is overwritten here.
            if (w_op == c_OP_SLT) r_result[0] <= w_set;
            r_carry_out <= w_add_class & w_cout;
            r_overflow  <= (w_op == c_OP_ADD) & (r_carry ^ w_cout);
         end
      end
   end

   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_DONE);
   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;
   assign zero      = ~|r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_exec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial_exec
// Brief    : Scoreboard bench for alu_serial_exec with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_serial_exec;

   localparam int W = 24;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [4:0]   alu_ctrl;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         zero;

   alu_serial_exec #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .alu_ctrl  (alu_ctrl),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      logic         z;
      int           due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: operate on whole words with ordinary arithmetic.
   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic [4:0] ic, input int due);
      exp_t         e;
      logic [W-1:0] aa, bb;
      logic [W:0]   s;
      logic         ovf;
      aa  = ic[4] ? ~ia : ia;
      bb  = ic[3] ? ~ib : ib;
      s   = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ic[3]};
      ovf = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
      e.res = '0; e.co = 1'b0; e.ov = 1'b0;
      case (ic[2:0])
         3'b000: e.res = aa & bb;
         3'b001: e.res = aa | bb;
         3'b010: begin e.res = s[W-1:0]; e.co = s[W]; e.ov = ovf; end
         3'b011: begin e.res = {{(W-1){1'b0}}, s[W-1] ^ ovf}; e.co = s[W]; end
         3'b100: e.res = aa ^ bb;
         default: e.res = '0;
      endcase
      e.z   = (e.res == '0);
      e.due = due;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
         end else begin
            e = sb.pop_front();
            check("result",    result,    e.res);
            check("carry_out", carry_out, e.co);
            check("overflow",  overflow,  e.ov);
            check("zero",      zero,      e.z);
            check("latency",   cyc,       e.due);
         end
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [4:0] ic);
      @(negedge clk);
      start = 1'b1; a = ia; b = ib; alu_ctrl = ic;
      @(posedge clk); #1;
      sb.push_back(model(ia, ib, ic, cyc + W));
      check("busy_after_accept", busy, 1);
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); alu_ctrl = 5'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 100);
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done within %0d cycles expected done", n);
      end
   endtask

   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [4:0] ic);
      issue(ia, ib, ic);
      wait_done();
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: pick = '0;
         1: pick = '1;
         2: pick = {1'b1, {(W-1){1'b0}}};
         3: pick = {1'b0, {(W-1){1'b1}}};
         default: pick = W'($urandom);
      endcase
   endfunction

   initial begin
      logic [W-1:0] s2a, s2b;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; alu_ctrl = '0;
      repeat (3) @(negedge clk);
      check("rst_result",   result,    0);
      check("rst_carry",    carry_out, 0);
      check("rst_overflow", overflow,  0);
      check("rst_zero",     zero,      1);
      check("rst_busy",     busy,      0);
      check("rst_done",     done,      0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_op(24'h7FFFFF, 24'h000001, 5'b00010);
      run_op(24'd5,      24'd7,      5'b01010);
      run_op(24'd7,      24'd7,      5'b01010);
      run_op(24'hFFFFFF, 24'h000001, 5'b01011);
      run_op(24'h7FFFFF, 24'h800000, 5'b01011);
      run_op(24'h800000, 24'h7FFFFF, 5'b01011);
      run_op(24'h000000, 24'h000000, 5'b11000);
      run_op(24'hF0F0F0, 24'hFF00FF, 5'b00000);
      run_op(24'hF0F0F0, 24'hFF00FF, 5'b00100);
      run_op(24'hF0F0F0, 24'hFF00FF, 5'b00111);
      run_op(24'hF0F0F0, 24'hFF00FF, 5'b00001);

      // Start pulses during RUN must be ignored.
      issue(24'h123456, 24'h00ABCD, 5'b00010);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         start = 1'b1; a = W'($urandom); b = W'($urandom); alu_ctrl = 5'($urandom_range(0, 4));
         @(negedge clk);
         start = 1'b0;
      end
      wait_done();

      // Start held high: second op accepted one cycle after Done.
      s2a = W'($urandom); s2b = W'($urandom);
      @(negedge clk);
      start = 1'b1; a = 24'h400000; b = 24'h400000; alu_ctrl = 5'b00010;
      @(posedge clk); #1;
      sb.push_back(model(24'h400000, 24'h400000, 5'b00010, cyc + W));
      sb.push_back(model(s2a, s2b, 5'b01010, cyc + 2 * W + 2));
      a = s2a; b = s2b; alu_ctrl = 5'b01010;
      wait_done();
      @(negedge clk);
      @(posedge clk); #1;
      check("busy_back_to_back", busy, 1);
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Reset while processing bit 10 aborts without Done.
      issue(24'hABCDEF, 24'h111111, 5'b00010);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_result",   result,    0);
      check("abort_carry",    carry_out, 0);
      check("abort_overflow", overflow,  0);
      check("abort_zero",     zero,      1);
      check("abort_busy",     busy,      0);
      check("abort_done",     done,      0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      run_op(24'hABCDEF, 24'h111111, 5'b01010);

      for (int i = 0; i < 40; i++) begin
         run_op(pick(), pick(), {2'($urandom), 3'($urandom_range(0, 7))});
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
